// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a requester and the apb_slave_mem word store.
interface apb_slave_mem_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
);
  logic                      pselx;
  logic                      penable;
  logic                      pwrite;
  logic [ADDRESS_WIDTH-1:0]  paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave word memory with programmable wait states and address range checks.
// Optional: define APB_SLAVE_PROT_CHECK_EN to reject non-secure (pprot[1]) writes.
//
// state      | meaning
// IDLE       | no transfer; waiting for a setup phase
// SETUP      | setup captured; waiting for the first access cycle
// WAIT_STATE | access phase, wait counter running, pready low
// ACCESS     | pready high; next access edge completes the transfer
module apb_slave_mem #(
  parameter int                       ADDRESS_WIDTH = 12,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = 12'h000,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = 12'h0FC,
  parameter int                       WAIT_STATES   = 2
) (
  input logic            pclk,
  input logic            preset_n,
  apb_slave_mem_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DEPTH  = int'((MAX_ADDRESS - MIN_ADDRESS) >> 2) + 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SETUP      = 2'd1;
  localparam logic [1:0] WAIT_STATE = 2'd2;
  localparam logic [1:0] ACCESS     = 2'd3;

  logic [1:0]               state;
  logic [3:0]               wait_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        strb_q;
  logic [2:0]               prot_q;
  logic                     pready_q;
  logic                     pslverr_q;
  logic [DATA_WIDTH-1:0]    prdata_q;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic                     setup_seen;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic                     sel_write;
  logic [ADDRESS_WIDTH:0]   off;
  logic [IDX_W-1:0]         idx;
  logic                     illegal;
  logic                     prot_err;
  logic                     xfer_err;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     unused_off;

  assign setup_seen = bus.pselx & ~bus.penable;

  // In IDLE the response is built straight from the bus so a zero-wait
  // transfer can raise pready on the setup edge itself.
  assign sel_addr  = (state == IDLE) ? bus.paddr  : addr_q;
  assign sel_write = (state == IDLE) ? bus.pwrite : write_q;

  // Extra bit of the offset is the borrow: set when the address is below MIN_ADDRESS.
  assign off        = {1'b0, sel_addr} - {1'b0, MIN_ADDRESS};
  assign idx        = off[IDX_W+1:2];
  assign unused_off = ^{off[ADDRESS_WIDTH-1:IDX_W+2], off[1:0]};
  assign illegal    = off[ADDRESS_WIDTH] | (sel_addr > MAX_ADDRESS) | (sel_addr[1:0] != 2'b00);

`ifdef APB_SLAVE_PROT_CHECK_EN
  logic [2:0] sel_prot;
  assign sel_prot = (state == IDLE) ? bus.pprot : prot_q;
  assign prot_err = sel_write & sel_prot[1];
`else
  logic unused_prot;
  assign unused_prot = ^prot_q;
  assign prot_err    = 1'b0;
`endif

  assign xfer_err = illegal | prot_err;
  assign rd_word  = (!xfer_err && !sel_write) ? mem[idx] : '0;

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_seen) begin
            addr_q   <= bus.paddr;
            write_q  <= bus.pwrite;
            wdata_q  <= bus.pwdata;
            strb_q   <= bus.pstrb;
            prot_q   <= bus.pprot;
            wait_cnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= xfer_err;
              prdata_q  <= rd_word;
              state     <= ACCESS;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP, WAIT_STATE: begin
          if (!bus.pselx) begin
            state <= IDLE;
          end else if (bus.penable) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= xfer_err;
              prdata_q  <= rd_word;
              state     <= ACCESS;
            end else begin
              state <= WAIT_STATE;
            end
          end
        end
        ACCESS: begin
          if (!bus.pselx || bus.penable) begin
            if (bus.pselx && write_q && !xfer_err) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
              end
            end
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 12, SHALL set the paddr width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the pwdata/prdata width; the pstrb width SHALL be DATA_WIDTH/8.
REQ-003 Parameter MIN_ADDRESS, default 12'h000, SHALL be the lowest legal byte address.
REQ-004 Parameter MAX_ADDRESS, default 12'h0FC, SHALL be the highest legal word address; depth = (MAX_ADDRESS-MIN_ADDRESS)/4+1 words (64 by default).
REQ-005 Parameter WAIT_STATES, default 2, range 0..15, SHALL set the pready-low cycles per transfer.
REQ-006 Ports (name, direction, width, meaning):
- pclk, in, 1, clock; all logic on the rising edge.
- preset_n, in, 1, synchronous active-low reset.
- pselx, in, 1, slave select.
- penable, in, 1, access phase.
- pwrite, in, 1, 1 = write, 0 = read.
- paddr, in, ADDRESS_WIDTH, byte address.
- pwdata, in, DATA_WIDTH, write data.
- pstrb, in, DATA_WIDTH/8, write byte strobes.
- pprot, in, 3, protection type.
- pready, out, 1, transfer complete.
- prdata, out, DATA_WIDTH, read data.
- pslverr, out, 1, transfer error.

Function
REQ-007 The FSM SHALL use states IDLE, SETUP, WAIT_STATE and ACCESS.
REQ-008 Setup capture: an edge sampling pselx=1, penable=0 SHALL latch paddr, pwrite, pwdata, pstrb and pprot, load the wait counter with WAIT_STATES, and enter SETUP.
REQ-009 pready SHALL be registered and SHALL go high in access cycle WAIT_STATES+1, where the first cycle with penable=1 is cycle 1. With WAIT_STATES=0, pready SHALL be high in the first access cycle.
REQ-010 While pselx=1, penable=1 and the counter is >0, the FSM SHALL stay in WAIT_STATE, decrement the counter each edge, and hold pready=0.
REQ-011 Completion: the edge sampling pselx=1, penable=1, pready=1 SHALL complete the transfer, drop pready to 0 and return to IDLE.
REQ-012 A legal write SHALL update only the bytes whose pstrb bit is 1, at the completion edge.
REQ-013 pstrb=0 on a write SHALL leave memory unchanged and SHALL NOT raise pslverr.
REQ-014 On a legal read, prdata SHALL show the addressed word while pready=1 and SHALL be 0 otherwise; pstrb SHALL be ignored on reads.
REQ-015 A transfer is illegal if paddr < MIN_ADDRESS, paddr > MAX_ADDRESS, or paddr[1:0] != 0. An illegal transfer SHALL assert pslverr=1 in its pready cycle, perform no write, and return prdata=0.
REQ-016 pslverr SHALL be 0 whenever pready=0.
REQ-017 If pselx falls before completion, the FSM SHALL go to IDLE with no write and pready=0.
REQ-018 Back-to-back transfers: a setup in the cycle after completion SHALL be accepted with no extra idle cycle.
REQ-019 penable=1 seen in IDLE without a preceding setup SHALL be ignored.
REQ-020 Memory address SHALL be (paddr-MIN_ADDRESS)>>2, truncated to log2(depth) bits.

Reset
REQ-021 While preset_n=0 at an edge, the FSM SHALL go to IDLE and pready, pslverr, prdata, the wait counter and all latched fields SHALL be 0.
REQ-022 Every memory word SHALL reset to 0.
REQ-023 A reset during WAIT_STATE or ACCESS SHALL abort the transfer with no memory update.

Configuration
REQ-024 With macro APB_SLAVE_PROT_CHECK_EN defined, a write with pprot[1]=1 (non-secure) SHALL complete with pslverr=1 and no memory update; reads SHALL be unaffected.
REQ-025 Without APB_SLAVE_PROT_CHECK_EN, pprot SHALL be latched but SHALL NOT affect behaviour.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Write 32'hDEADBEEF to 12'h010 with pstrb=4'hF and WAIT_STATES=2, then read 12'h010 -> pready low 2 access cycles then high in cycle 3; prdata=32'hDEADBEEF; pslverr=0.
- Write 32'h11223344 with pstrb=4'b0101 over 32'hDEADBEEF at 12'h010, then read -> prdata=32'hDE22BE44.
- Read 12'h100 and write 12'h012 -> pslverr=1 in the pready cycle; prdata=0; memory unchanged.
- pselx dropped in the first WAIT_STATE cycle of a write to 12'h020 -> IDLE; a later read of 12'h020 returns 0.
- preset_n=0 in mid-access, then read 12'h010 -> pready/pslverr/prdata are 0 during reset; the read returns 0.
- With APB_SLAVE_PROT_CHECK_EN, write 12'h030 with pprot=3'b010 -> pslverr=1; a later read returns 0. Without the macro, the same write succeeds.
